// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg
// Shared definitions for the machine-mode interrupt sequencer:
//   - state_t               : sequencer state encoding
//   - MTVEC_MODE_VECTORED   : mtvec[1:0] code that selects vectored mode
//   - DEF_CAUSE_BASE        : mcause code reported for interrupt source 0
//   - mcause_int_bit()      : bit position of the mcause "interrupt" flag
package trap_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_ENTER   = 3'd2,
        ST_HANDLER = 3'd3,
        ST_EXIT    = 3'd4
    } state_t;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    localparam int DEF_CAUSE_BASE = 16;

    // The interrupt flag always lives in the MSB of mcause.
    function automatic int mcause_int_bit(input int xlen);
        return xlen - 1;
    endfunction

endpackage

// File: rtl/trap_ctrl_prio_enc.sv
// prio_enc
// Fixed-priority encoder: the lowest set index of i_req wins.
// Ports:
//   i_req   in  N      request vector
//   o_valid out 1      at least one request is set
//   o_idx   out IDX_W  binary index of the winning request (0 when none)
module prio_enc
    import trap_ctrl_pkg::*;
#(
    parameter int N     = 6,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    // Scanning from the top down lets the lowest set index overwrite last.
    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                o_idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl
// Machine-mode interrupt sequencer. Latches rising edges of the external
// interrupt lines, picks the lowest-index enabled one, waits for an
// instruction boundary, redirects fetch to the trap vector and captures
// mepc/mcause/mtval. An mret retiring inside the handler redirects back
// to mepc. Only one trap is in service at a time.
// Ports:
//   i_CLK       clock, rising edge
//   i_RST       asynchronous active-high reset
//   i_MEI       interrupt request levels (synchronous to i_CLK)
//   i_MIE       per-source enable mask
//   i_MTVEC     trap base, [1:0]==2'b01 selects vectored mode
//   i_RETIRE    one instruction retires this cycle
//   i_PC        PC of the next instruction (valid with i_RETIRE)
//   i_INSTR     retiring instruction word (valid with i_RETIRE)
//   i_MRET      retiring instruction is mret (qualified by i_RETIRE)
//   o_REDIRECT  one-cycle PC redirect / flush
//   o_TARGET    redirect address
//   o_ACK       one-hot acknowledge of the serviced source
//   o_IN_TRAP   a handler is active
//   o_MEPC      captured return PC
//   o_MCAUSE    captured cause
//   o_MTVAL     captured instruction word
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int N_SRC      = 6,
    parameter int XLEN       = 32,
    parameter int CAUSE_BASE = DEF_CAUSE_BASE
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic [N_SRC-1:0] i_MEI,
    input  logic [N_SRC-1:0] i_MIE,
    input  logic [XLEN-1:0]  i_MTVEC,
    input  logic             i_RETIRE,
    input  logic [XLEN-1:0]  i_PC,
    input  logic [XLEN-1:0]  i_INSTR,
    input  logic             i_MRET,
    output logic             o_REDIRECT,
    output logic [XLEN-1:0]  o_TARGET,
    output logic [N_SRC-1:0] o_ACK,
    output logic             o_IN_TRAP,
    output logic [XLEN-1:0]  o_MEPC,
    output logic [XLEN-1:0]  o_MCAUSE,
    output logic [XLEN-1:0]  o_MTVAL
);

    localparam int IDX_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int IRQ_BIT = mcause_int_bit(XLEN);

    state_t             state_q, state_d;
    logic [N_SRC-1:0]   mei_q;
    logic [N_SRC-1:0]   pend_q, pend_d;
    logic               redirect_q, redirect_d;
    logic [XLEN-1:0]    target_q, target_d;
    logic [N_SRC-1:0]   ack_q, ack_d;
    logic               in_trap_q, in_trap_d;
    logic [XLEN-1:0]    mepc_q, mepc_d;
    logic [XLEN-1:0]    mcause_q, mcause_d;
    logic [XLEN-1:0]    mtval_q, mtval_d;

    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   elig;
    logic [N_SRC-1:0]   clr;
    logic               enc_valid;
    logic [IDX_W-1:0]   enc_idx;
    logic [XLEN-1:0]    cause_code;
    logic [XLEN-1:0]    vec_base;
    logic [XLEN-1:0]    entry_target;

    prio_enc #(
        .N     (N_SRC),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .i_req   (elig),
        .o_valid (enc_valid),
        .o_idx   (enc_idx)
    );

    // Edge detection, eligibility and entry-address arithmetic. The ack
    // register is one-hot on the serviced source during ENTER, so it doubles
    // as the pending-clear mask; OR-ing new edges in afterwards lets a fresh
    // edge survive a same-cycle clear.
    always_comb begin
        rise         = i_MEI & ~mei_q;
        elig         = pend_q & i_MIE;
        clr          = (state_q == ST_ENTER) ? ack_q : '0;
        cause_code   = XLEN'(CAUSE_BASE) + XLEN'(enc_idx);
        vec_base     = {i_MTVEC[XLEN-1:2], 2'b00};
        entry_target = (i_MTVEC[1:0] == MTVEC_MODE_VECTORED)
                       ? vec_base + (cause_code << 2)
                       : vec_base;
    end

    // Next-state logic. Redirect, target and ack are computed one cycle ahead
    // so that their registered copies are high exactly while the state is
    // ENTER or EXIT.
    always_comb begin
        state_d    = state_q;
        pend_d     = (pend_q & ~clr) | rise;
        redirect_d = 1'b0;
        target_d   = '0;
        ack_d      = '0;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;

        case (state_q)
            ST_IDLE: begin
                if (enc_valid) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!enc_valid) begin
                    state_d = ST_IDLE;
                end else if (i_RETIRE) begin
                    state_d    = ST_ENTER;
                    redirect_d = 1'b1;
                    target_d   = entry_target;
                    ack_d      = N_SRC'(1) << enc_idx;
                    mepc_d     = i_PC;
                    mtval_d    = i_INSTR;
                    mcause_d   = cause_code | (XLEN'(1) << IRQ_BIT);
                end
            end
            ST_ENTER: begin
                state_d = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (i_RETIRE && i_MRET) begin
                    state_d    = ST_EXIT;
                    redirect_d = 1'b1;
                    target_d   = mepc_q;
                end
            end
            ST_EXIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_trap_d = (state_d == ST_HANDLER) || (state_d == ST_EXIT);
    end

    // All sequencer state and outputs are registered; reset drops every
    // output immediately, including any redirect in flight.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q    <= ST_IDLE;
            mei_q      <= '0;
            pend_q     <= '0;
            redirect_q <= 1'b0;
            target_q   <= '0;
            ack_q      <= '0;
            in_trap_q  <= 1'b0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            state_q    <= state_d;
            mei_q      <= i_MEI;
            pend_q     <= pend_d;
            redirect_q <= redirect_d;
            target_q   <= target_d;
            ack_q      <= ack_d;
            in_trap_q  <= in_trap_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

    assign o_REDIRECT = redirect_q;
    assign o_TARGET   = target_q;
    assign o_ACK      = ack_q;
    assign o_IN_TRAP  = in_trap_q;
    assign o_MEPC     = mepc_q;
    assign o_MCAUSE   = mcause_q;
    assign o_MTVAL    = mtval_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl
// Directed scoreboard bench for trap_ctrl. Stimulus pushes the expected
// redirect into a queue; a monitor on the falling edge pops and compares
// every redirect the DUT presents, and flags any redirect nobody expected.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  mei = '0;
    logic [5:0]  mie = '0;
    logic [31:0] mtvec = '0;
    logic        retire = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic        mret = 1'b0;
    logic        redirect;
    logic [31:0] target;
    logic [5:0]  ack;
    logic        inTrap;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;

    int nCompared = 0;
    int nMismatched = 0;

    typedef struct {
        string       name;
        logic        isEntry;
        logic [31:0] target;
        logic [5:0]  ack;
        logic [31:0] mcause;
        logic [31:0] mepc;
        logic [31:0] mtval;
    } exp_t;

    exp_t expQ[$];

    trap_ctrl #(
        .N_SRC      (6),
        .XLEN       (32),
        .CAUSE_BASE (16)
    ) dut (
        .i_CLK      (clk),
        .i_RST      (rst),
        .i_MEI      (mei),
        .i_MIE      (mie),
        .i_MTVEC    (mtvec),
        .i_RETIRE   (retire),
        .i_PC       (pc),
        .i_INSTR    (instr),
        .i_MRET     (mret),
        .o_REDIRECT (redirect),
        .o_TARGET   (target),
        .o_ACK      (ack),
        .o_IN_TRAP  (inTrap),
        .o_MEPC     (mepc),
        .o_MCAUSE   (mcause),
        .o_MTVAL    (mtval)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulseMei(input logic [5:0] m);
        mei = m;
        tick();
        mei = '0;
    endtask

    // One retiring instruction, held for exactly one clock.
    task automatic applyStimulus(input logic [31:0] nextPc, input logic [31:0] word, input logic isMret);
        retire = 1'b1;
        pc     = nextPc;
        instr  = word;
        mret   = isMret;
        tick();
        retire = 1'b0;
        mret   = 1'b0;
    endtask

    task automatic expectEntry(input string name, input logic [31:0] tgt, input logic [5:0] a,
                               input logic [31:0] cause, input logic [31:0] epc, input logic [31:0] tval);
        exp_t e;
        e.name = name; e.isEntry = 1'b1; e.target = tgt; e.ack = a;
        e.mcause = cause; e.mepc = epc; e.mtval = tval;
        expQ.push_back(e);
    endtask

    task automatic expectExit(input string name, input logic [31:0] tgt);
        exp_t e;
        e.name = name; e.isEntry = 1'b0; e.target = tgt; e.ack = '0;
        e.mcause = '0; e.mepc = '0; e.mtval = '0;
        expQ.push_back(e);
    endtask

    // Scoreboard monitor: every redirect must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && redirect === 1'b1) begin
            if (expQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL unexpected_redirect: got target 0x%08h, expected no redirect", target);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput({e.name, ".target"}, target, e.target);
                checkOutput({e.name, ".ack"}, 32'(ack), 32'(e.ack));
                if (e.isEntry) begin
                    checkOutput({e.name, ".mcause"}, mcause, e.mcause);
                    checkOutput({e.name, ".mepc"}, mepc, e.mepc);
                    checkOutput({e.name, ".mtval"}, mtval, e.mtval);
                    checkOutput({e.name, ".in_trap"}, 32'(inTrap), 32'd0);
                end else begin
                    checkOutput({e.name, ".in_trap"}, 32'(inTrap), 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #12;
        checkOutput("reset.redirect", 32'(redirect), 32'd0);
        checkOutput("reset.in_trap", 32'(inTrap), 32'd0);
        checkOutput("reset.mepc", mepc, 32'd0);
        checkOutput("reset.mcause", mcause, 32'd0);
        @(posedge clk); #1;
        rst   = 1'b0;
        mie   = 6'h3F;
        mtvec = 32'h100;
        tick(2);

        // Basic direct-mode entry and mret return.
        pulseMei(6'b000100);
        tick(2);
        expectEntry("basic_entry", 32'h100, 6'b000100, 32'h8000_0012, 32'h40, 32'h13);
        applyStimulus(32'h40, 32'h0000_0013, 1'b0);
        tick(2);
        checkOutput("basic.in_trap_high", 32'(inTrap), 32'd1);
        expectExit("basic_exit", 32'h40);
        applyStimulus(32'h88, 32'h3020_0073, 1'b0 | 1'b1);
        tick(2);
        checkOutput("basic.in_trap_low", 32'(inTrap), 32'd0);

        // Vectored mode: sources 1 and 5 together, 1 first then 5 back-to-back.
        mtvec = 32'h201;
        pulseMei(6'b100010);
        tick(2);
        expectEntry("vec_src1", 32'h244, 6'b000010, 32'h8000_0011, 32'h500, 32'hAAAA_0001);
        applyStimulus(32'h500, 32'hAAAA_0001, 1'b0);
        tick(2);
        expectExit("vec_src1_exit", 32'h500);
        applyStimulus(32'h600, 32'h3020_0073, 1'b1);
        tick(2);
        expectEntry("vec_src5", 32'h254, 6'b100000, 32'h8000_0015, 32'h504, 32'hAAAA_0005);
        applyStimulus(32'h504, 32'hAAAA_0005, 1'b0);
        tick(2);
        expectExit("vec_src5_exit", 32'h504);
        applyStimulus(32'h610, 32'h3020_0073, 1'b1);
        tick(2);

        // Masked request stays pending until enabled.
        mtvec = 32'h100;
        mie   = 6'h37;
        pulseMei(6'b001000);
        tick(2);
        applyStimulus(32'h700, 32'h0000_0013, 1'b0);
        tick(2);
        checkOutput("masked.in_trap", 32'(inTrap), 32'd0);
        mie = 6'h3F;
        tick(2);
        expectEntry("unmasked_src3", 32'h100, 6'b001000, 32'h8000_0013, 32'h704, 32'h1111_2222);
        applyStimulus(32'h704, 32'h1111_2222, 1'b0);
        tick(2);
        expectExit("unmasked_src3_exit", 32'h704);
        applyStimulus(32'h800, 32'h3020_0073, 1'b1);
        tick(2);

        // Mask withdrawn while draining: back to idle without a redirect.
        pulseMei(6'b001000);
        tick(2);
        mie = 6'h37;
        tick();
        applyStimulus(32'h900, 32'h0000_0013, 1'b0);
        tick(3);
        checkOutput("withdrawn.in_trap", 32'(inTrap), 32'd0);
        checkOutput("withdrawn.mepc_held", mepc, 32'h704);

        // Interrupt arriving during the handler waits for mret.
        pulseMei(6'b010000);
        tick(2);
        expectEntry("handler_src4", 32'h100, 6'b010000, 32'h8000_0014, 32'hA00, 32'h2222_3333);
        applyStimulus(32'hA00, 32'h2222_3333, 1'b0);
        tick(2);
        pulseMei(6'b000001);
        tick(2);
        applyStimulus(32'h104, 32'h0000_0013, 1'b0);
        applyStimulus(32'h108, 32'h0000_0013, 1'b0);
        tick();
        checkOutput("nested.in_trap", 32'(inTrap), 32'd1);
        expectExit("handler_src4_exit", 32'hA00);
        applyStimulus(32'h10C, 32'h3020_0073, 1'b1);
        tick(2);
        expectEntry("after_src0", 32'h100, 6'b000001, 32'h8000_0010, 32'hA00, 32'h4444_5555);
        applyStimulus(32'hA00, 32'h4444_5555, 1'b0);
        tick(2);
        expectExit("after_src0_exit", 32'hA00);
        applyStimulus(32'h110, 32'h3020_0073, 1'b1);
        tick(2);

        // Stray mret in idle is ignored.
        applyStimulus(32'hB00, 32'h3020_0073, 1'b1);
        tick(2);
        checkOutput("stray_mret.in_trap", 32'(inTrap), 32'd0);

        // Reset during the handler with pending work.
        mie = 6'h3F;
        pulseMei(6'b000010);
        tick(2);
        expectEntry("prereset_src1", 32'h100, 6'b000010, 32'h8000_0011, 32'hC00, 32'h5555_6666);
        applyStimulus(32'hC00, 32'h5555_6666, 1'b0);
        tick(2);
        pulseMei(6'b100000);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midreset.redirect", 32'(redirect), 32'd0);
        checkOutput("midreset.in_trap", 32'(inTrap), 32'd0);
        checkOutput("midreset.ack", 32'(ack), 32'd0);
        checkOutput("midreset.target", target, 32'd0);
        checkOutput("midreset.mepc", mepc, 32'd0);
        checkOutput("midreset.mcause", mcause, 32'd0);
        checkOutput("midreset.mtval", mtval, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(3);
        applyStimulus(32'hD00, 32'h0000_0013, 1'b0);
        applyStimulus(32'hD04, 32'h3020_0073, 1'b1);
        tick(4);
        checkOutput("postreset.in_trap", 32'(inTrap), 32'd0);
        checkOutput("postreset.mepc", mepc, 32'd0);

        checkOutput("scoreboard.leftover", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode interrupt sequencer between the six external interrupt lines, the CSR file and the fetch/PC unit.
- Latches pending interrupts and picks one by fixed priority.
- Waits for an instruction boundary, then redirects the PC to the trap vector and supplies mepc/mcause/mtval values for the CSR file.
- Sequences the return on mret.
- No nesting: one trap is in service at a time.

Parameters:
- N_SRC, 6, number of external interrupt sources (max 16).
- XLEN, 32, data/address width.
- CAUSE_BASE, 16, mcause code of source 0 (source k reports CAUSE_BASE+k).

Ports:
- i_CLK  in  1  clock, rising edge. One clock domain: i_CLK.
- i_RST  in  1  reset, asynchronous, active-high: i_RST.
- i_MEI  in  N_SRC  interrupt request levels, already synchronous to i_CLK.
- i_MIE  in  N_SRC  per-source enable mask from the CSR file.
- i_MTVEC  in  XLEN  trap base; bits[1:0]==2'b01 selects vectored mode.
- i_RETIRE  in  1  instruction boundary strobe: one instruction retires this cycle.
- i_PC  in  XLEN  PC of the next instruction to execute; valid when i_RETIRE=1.
- i_INSTR  in  XLEN  the retiring instruction word; valid when i_RETIRE=1.
- i_MRET  in  1  retiring instruction is mret; qualified by i_RETIRE.
- o_REDIRECT  out  1  one-cycle PC redirect and pipeline flush.
- o_TARGET  out  XLEN  redirect address; valid when o_REDIRECT=1.
- o_ACK  out  N_SRC  one-hot, one-cycle acknowledge of the serviced source.
- o_IN_TRAP  out  1  a handler is active.
- o_MEPC  out  XLEN  captured return PC.
- o_MCAUSE  out  XLEN  captured cause.
- o_MTVAL  out  XLEN  captured instruction word.

Behaviour:
- Reset values: all outputs 0, pending register 0, state IDLE.
- Pending register pend[N_SRC-1:0]:
  - Bit k sets on a rising edge of i_MEI[k]; edge detection uses a registered copy of i_MEI.
  - Bit k clears in the ENTER cycle when k is the serviced source.
  - Set and clear in the same cycle: set wins (a new edge is kept).
- Eligible sources: elig = pend & i_MIE. Priority: the lowest index wins.
- State IDLE:
  - elig != 0 -> DRAIN.
  - i_MRET & i_RETIRE in IDLE is ignored: no redirect.
- State DRAIN:
  - elig == 0 (mask cleared meanwhile) -> IDLE, no trap.
  - Else, on i_RETIRE:
    - Capture o_MEPC <= i_PC and o_MTVAL <= i_INSTR.
    - Capture sel = highest-priority eligible source at that cycle.
    - o_MCAUSE <= {1'b1, zero pad, CAUSE_BASE+sel}.
    - Next state ENTER.
- State ENTER (exactly 1 cycle):
  - o_REDIRECT=1 and o_ACK[sel]=1; pend[sel] clears; o_IN_TRAP rises next cycle.
  - o_TARGET = {i_MTVEC[XLEN-1:2],2'b00}.
  - In vectored mode, o_TARGET additionally adds 4*(CAUSE_BASE+sel). Arithmetic is modulo 2^XLEN (wrap-around allowed).
  - Next state HANDLER.
- State HANDLER:
  - o_IN_TRAP=1. New edges keep latching into pend, but no selection is made.
  - i_RETIRE & i_MRET -> EXIT.
- State EXIT (exactly 1 cycle):
  - o_REDIRECT=1, o_TARGET=o_MEPC; o_IN_TRAP falls next cycle.
  - Next state IDLE. An interrupt that pended during the handler re-enters DRAIN one cycle later (back-to-back service).
- Latency: retire in DRAIN -> redirect on the next cycle. mret retire -> redirect on the next cycle.
- o_MEPC, o_MCAUSE and o_MTVAL hold their values until the next DRAIN capture.
- Reset asserted mid-trap (any state): everything returns to reset values immediately; no redirect is issued.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE, DRAIN, ENTER, HANDLER, EXIT;
  - the vectored-mode code 2'b01;
  - CAUSE_BASE;
  - the mcause interrupt-bit position.
- One sub-module, prio_enc: N_SRC-bit lowest-index-first priority encoder producing a valid flag and a binary index.

Test Plan:
- Basic entry/return:
  - Stimulus: i_MIE=6'h3F, i_MTVEC=0x100 (direct mode); pulse i_MEI[2]; i_RETIRE with i_PC=0x40, i_INSTR=0x00000013.
  - Response: o_REDIRECT with o_TARGET=0x100; o_ACK=6'b000100; o_MCAUSE=0x80000012; o_MEPC=0x40; o_MTVAL=0x13.
  - Then i_MRET+i_RETIRE -> o_REDIRECT with o_TARGET=0x40; o_IN_TRAP falls.
- Vectored mode and priority:
  - Stimulus: i_MTVEC=0x201; i_MEI[5] and i_MEI[1] rise in the same cycle.
  - Response: source 1 is serviced first with o_TARGET=0x200+4*17=0x244.
  - After mret, source 5 is serviced back-to-back with o_TARGET=0x254.
- Masked/withdrawn request:
  - Stimulus: i_MEI[3] rises with i_MIE[3]=0.
  - Response: no redirect. Setting i_MIE[3]=1 later -> serviced; clearing i_MIE[3] while in DRAIN before i_RETIRE -> return to IDLE with no redirect.
- Interrupt during handler:
  - Stimulus: i_MEI[0] rises while o_IN_TRAP=1.
  - Response: no redirect until mret. After the EXIT redirect, DRAIN follows; the next retire produces entry for source 0 (o_MCAUSE=0x80000010).
- Stray mret:
  - Stimulus: i_MRET+i_RETIRE in IDLE.
  - Response: no o_REDIRECT; state stays IDLE.
- Reset mid-operation:
  - Stimulus: assert i_RST during HANDLER with pend nonzero.
  - Response: all outputs 0 asynchronously, pend cleared; after release, no trap occurs without a new edge.
